cachebusburst: RTL and testbench

Line-burst engine between the cache and the system bus. It accepts a line fetch or writeback request from the cache and splits it into BEATSPERLINE word beats on a valid/ready bus port. Read beats are assembled into the line-wide fetch buffer. The cache is told which word to supply for each writeback beat, and completion is acknowledged with a one-cycle pulse.

---
 rtl/cachebusburst_pkg.sv | 16 +
 rtl/cachebusburst_beatcnt.sv | 26 ++
 rtl/cachebusburst.sv | 117 +++++++++++
 tb/tb_cachebusburst.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cachebusburst_pkg.sv
// cachebusburst_pkg: FSM state type shared by the cache bus burst engine
// and the other cache controllers.
`default_nettype none

package cachebusburst_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } statetype;

endpackage

`default_nettype wire

// File: rtl/cachebusburst_beatcnt.sv
// cachebusbeatcnt: beat index within a cache line burst; wraps at the line end
// and flags the final beat.
`default_nettype none

module cachebusbeatcnt #(
  parameter int LOGBWPL = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clr,
  input  logic               en,
  output logic [LOGBWPL-1:0] count,
  output logic               last
);

  always_ff @(posedge clk) begin
    if (reset || clr) count <= '0;
    else if (en)      count <= count + 1'b1;
  end

  // Beat count is a power of two, so the final beat is the all-ones index.
  assign last = &count;

endmodule

`default_nettype wire

// File: rtl/cachebusburst.sv
// cachebusburst: splits cache line fetch/writeback requests into bus beats.
// Optional per-beat watchdog abort is built when CACHEBUS_TIMEOUT_EN is defined.
`default_nettype none

module cachebusburst
  import cachebusburst_pkg::*;
#(
  parameter int PA_BITS      = 32,
  parameter int AHBW         = 32,
  parameter int BEATSPERLINE = 4,
  parameter int LOGBWPL      = 2,
  parameter int TIMEOUT      = 255
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [1:0]                   CacheBusRW,
  input  logic [PA_BITS-1:0]           CacheBusAdr,
  input  logic                         FlushStage,
  input  logic [AHBW-1:0]              CacheReadDataWord,
  output logic                         CacheBusAck,
  output logic                         SelBusBeat,
  output logic [LOGBWPL-1:0]           BeatCount,
  output logic [BEATSPERLINE*AHBW-1:0] FetchBuffer,
  output logic                         BusBusy,
  output logic                         BusError,
  output logic                         BusValid,
  output logic                         BusWrite,
  output logic [PA_BITS-1:0]           BusAdr,
  output logic [AHBW-1:0]              BusWData,
  input  logic                         BusReady,
  input  logic [AHBW-1:0]              BusRData
);

  localparam int OFFBITS = $clog2(AHBW/8);

  statetype state, next_state;
  logic     beat_done;
  logic     last_beat;
  logic     timeout;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (CacheBusRW[0] && !FlushStage)      next_state = WRITE;
        else if (CacheBusRW[1] && !FlushStage) next_state = READ;
      end
      READ, WRITE: begin
        if (timeout || (beat_done && last_beat)) next_state = DONE;
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign BusValid    = (state == READ) || (state == WRITE);
  assign BusWrite    = (state == WRITE);
  assign SelBusBeat  = (state == WRITE);
  assign BusBusy     = (state != IDLE);
  assign CacheBusAck = (state == DONE);
  assign beat_done   = BusValid && BusReady;

  // Beat index replaces the word-offset field, so the line index never carries.
  assign BusAdr = BusValid ?
                  {CacheBusAdr[PA_BITS-1:OFFBITS+LOGBWPL], BeatCount, CacheBusAdr[OFFBITS-1:0]} :
                  '0;
  assign BusWData = SelBusBeat ? CacheReadDataWord : '0;

  cachebusbeatcnt #(.LOGBWPL(LOGBWPL)) u_beatcnt (
    .clk   (clk),
    .reset (reset),
    .clr   (state == IDLE),
    .en    (beat_done),
    .count (BeatCount),
    .last  (last_beat)
  );

  always_ff @(posedge clk) begin
    if (reset)
      FetchBuffer <= '0;
    else if ((state == READ) && beat_done)
      FetchBuffer[BeatCount*AHBW +: AHBW] <= BusRData;
  end

`ifdef CACHEBUS_TIMEOUT_EN
  localparam int WCW = ($clog2(TIMEOUT+1) > 8) ? $clog2(TIMEOUT+1) : 8;

  logic [WCW-1:0] wait_cnt;
  logic           err_q;

  always_ff @(posedge clk) begin
    if (reset || !BusValid || beat_done) wait_cnt <= '0;
    else                                 wait_cnt <= wait_cnt + 1'b1;
  end

  assign timeout = BusValid && (wait_cnt == WCW'(TIMEOUT));

  always_ff @(posedge clk) begin
    if (reset || (state == IDLE)) err_q <= 1'b0;
    else if (timeout)             err_q <= 1'b1;
  end

  assign BusError = (state == DONE) && err_q;
`else
  // Without the watchdog a stalled beat waits forever; TIMEOUT has no effect.
  assign timeout  = 1'b0 && (TIMEOUT != 0);
  assign BusError = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_cachebusburst.sv
// tb_cachebusburst: directed vector table plus hand-written multi-cycle
// sequences for the cache line burst engine.
`default_nettype none

module tb_cachebusburst;

  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   CacheBusRW;
  logic [31:0]  CacheBusAdr;
  logic         FlushStage;
  logic [31:0]  CacheReadDataWord;
  logic         CacheBusAck;
  logic         SelBusBeat;
  logic [1:0]   BeatCount;
  logic [127:0] FetchBuffer;
  logic         BusBusy;
  logic         BusError;
  logic         BusValid;
  logic         BusWrite;
  logic [31:0]  BusAdr;
  logic [31:0]  BusWData;
  logic         BusReady;
  logic [31:0]  BusRData;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cachebusburst #(
    .PA_BITS(32), .AHBW(32), .BEATSPERLINE(4), .LOGBWPL(2), .TIMEOUT(8)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .CacheBusRW        (CacheBusRW),
    .CacheBusAdr       (CacheBusAdr),
    .FlushStage        (FlushStage),
    .CacheReadDataWord (CacheReadDataWord),
    .CacheBusAck       (CacheBusAck),
    .SelBusBeat        (SelBusBeat),
    .BeatCount         (BeatCount),
    .FetchBuffer       (FetchBuffer),
    .BusBusy           (BusBusy),
    .BusError          (BusError),
    .BusValid          (BusValid),
    .BusWrite          (BusWrite),
    .BusAdr            (BusAdr),
    .BusWData          (BusWData),
    .BusReady          (BusReady),
    .BusRData          (BusRData)
  );

  typedef struct {
    logic [1:0]  rw;
    logic        ready;
    logic [31:0] rdata;
    logic [31:0] crd;
    logic        e_valid;
    logic        e_write;
    logic [1:0]  e_bc;
    logic        e_ack;
    logic        e_busy;
    logic [31:0] e_adr;
    logic [31:0] e_wdata;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mkv(input logic [1:0] rw, input logic ready,
                               input logic [31:0] rdata, input logic [31:0] crd,
                               input logic v, input logic w, input logic [1:0] bc,
                               input logic ack, input logic busy,
                               input logic [31:0] adr, input logic [31:0] wd);
    vec_t r;
    r.rw = rw; r.ready = ready; r.rdata = rdata; r.crd = crd;
    r.e_valid = v; r.e_write = w; r.e_bc = bc; r.e_ack = ack;
    r.e_busy = busy; r.e_adr = adr; r.e_wdata = wd;
    return r;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advances until CacheBusAck is seen (checked 1 time unit after negedge).
  task automatic wait_ack(input int budget, output logic seen);
    seen = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk); #1;
      if (CacheBusAck) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  logic seen;
  int   ack_at;

  initial begin
    // Zero-wait fetch of line 0x8000_0040.
    vecs[0]  = mkv(2'b10, 1, 32'h0,  32'h0,  0, 0, 0, 0, 0, 32'h0,        32'h0);
    vecs[1]  = mkv(2'b10, 1, 32'h11, 32'h0,  1, 0, 0, 0, 1, 32'h80000040, 32'h0);
    vecs[2]  = mkv(2'b10, 1, 32'h22, 32'h0,  1, 0, 1, 0, 1, 32'h80000044, 32'h0);
    vecs[3]  = mkv(2'b10, 1, 32'h33, 32'h0,  1, 0, 2, 0, 1, 32'h80000048, 32'h0);
    vecs[4]  = mkv(2'b10, 1, 32'h44, 32'h0,  1, 0, 3, 0, 1, 32'h8000004C, 32'h0);
    vecs[5]  = mkv(2'b00, 1, 32'h0,  32'h0,  0, 0, 0, 1, 1, 32'h0,        32'h0);
    vecs[6]  = mkv(2'b00, 1, 32'h0,  32'h0,  0, 0, 0, 0, 0, 32'h0,        32'h0);
    // Writeback with two wait states on beat 1.
    vecs[7]  = mkv(2'b01, 1, 32'h0,  32'hA0, 0, 0, 0, 0, 0, 32'h0,        32'h0);
    vecs[8]  = mkv(2'b01, 1, 32'h0,  32'hA0, 1, 1, 0, 0, 1, 32'h80000040, 32'hA0);
    vecs[9]  = mkv(2'b01, 0, 32'h0,  32'hA1, 1, 1, 1, 0, 1, 32'h80000044, 32'hA1);
    vecs[10] = mkv(2'b01, 0, 32'h0,  32'hB1, 1, 1, 1, 0, 1, 32'h80000044, 32'hB1);
    vecs[11] = mkv(2'b01, 1, 32'h0,  32'hA1, 1, 1, 1, 0, 1, 32'h80000044, 32'hA1);
    vecs[12] = mkv(2'b01, 1, 32'h0,  32'hA2, 1, 1, 2, 0, 1, 32'h80000048, 32'hA2);
    vecs[13] = mkv(2'b01, 1, 32'h0,  32'hA3, 1, 1, 3, 0, 1, 32'h8000004C, 32'hA3);
    vecs[14] = mkv(2'b00, 1, 32'h0,  32'h0,  0, 0, 0, 1, 1, 32'h0,        32'h0);
    vecs[15] = mkv(2'b00, 1, 32'h0,  32'h0,  0, 0, 0, 0, 0, 32'h0,        32'h0);

    reset = 1'b1; CacheBusRW = 2'b00; CacheBusAdr = 32'h80000040; FlushStage = 1'b0;
    CacheReadDataWord = 32'h0; BusReady = 1'b0; BusRData = 32'h0;
    repeat (2) @(negedge clk);
    reset = 1'b0; #1;
    chk("reset_valid", BusValid, 1'b0);
    chk("reset_busy",  BusBusy, 1'b0);
    chk("reset_ack",   CacheBusAck, 1'b0);
    chk("reset_bc",    BeatCount, 2'd0);
    chk("reset_fb",    FetchBuffer, 128'h0);
    chk("reset_err",   BusError, 1'b0);

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      CacheBusRW = vecs[i].rw; BusReady = vecs[i].ready;
      BusRData = vecs[i].rdata; CacheReadDataWord = vecs[i].crd;
      #1;
      chk($sformatf("v%0d_valid", i), BusValid,    vecs[i].e_valid);
      chk($sformatf("v%0d_write", i), BusWrite,    vecs[i].e_write);
      chk($sformatf("v%0d_sel", i),   SelBusBeat,  vecs[i].e_write);
      chk($sformatf("v%0d_bc", i),    BeatCount,   vecs[i].e_bc);
      chk($sformatf("v%0d_ack", i),   CacheBusAck, vecs[i].e_ack);
      chk($sformatf("v%0d_busy", i),  BusBusy,     vecs[i].e_busy);
      chk($sformatf("v%0d_adr", i),   BusAdr,      vecs[i].e_adr);
      chk($sformatf("v%0d_wdata", i), BusWData,    vecs[i].e_wdata);
      chk($sformatf("v%0d_err", i),   BusError,    1'b0);
    end
    chk("fetch_line", FetchBuffer, 128'h00000044_00000033_00000022_00000011);

    // Both request bits: writeback first, then the held fetch after one idle cycle.
    @(negedge clk); CacheBusRW = 2'b11; BusReady = 1'b1; BusRData = 32'h55; #1;
    chk("both_idle_busy", BusBusy, 1'b0);
    @(negedge clk); #1;
    chk("both_write", BusWrite, 1'b1);
    chk("both_sel",   SelBusBeat, 1'b1);
    wait_ack(10, seen);
    chk("both_wr_ack", seen, 1'b1);
    CacheBusRW = 2'b10;
    @(negedge clk); #1;
    chk("both_gap_valid", BusValid, 1'b0);
    chk("both_gap_busy",  BusBusy, 1'b0);
    @(negedge clk); #1;
    chk("both_rd_valid", BusValid, 1'b1);
    chk("both_rd_write", BusWrite, 1'b0);
    wait_ack(10, seen);
    chk("both_rd_ack", seen, 1'b1);
    CacheBusRW = 2'b00;
    chk("both_rd_line", FetchBuffer, {4{32'h55}});

    // Flush in IDLE blocks the start; flush mid-burst does not cut it short.
    @(negedge clk); CacheBusRW = 2'b10; FlushStage = 1'b1; BusRData = 32'h66;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #1;
      chk($sformatf("flush_idle%0d_valid", k), BusValid, 1'b0);
      chk($sformatf("flush_idle%0d_ack", k), CacheBusAck, 1'b0);
    end
    FlushStage = 1'b0;
    @(negedge clk); #1;
    chk("flush_start_valid", BusValid, 1'b1);
    FlushStage = 1'b1;
    wait_ack(10, seen);
    chk("flush_mid_ack", seen, 1'b1);
    CacheBusRW = 2'b00; FlushStage = 1'b0;
    chk("flush_mid_line", FetchBuffer, {4{32'h66}});

    // Reset during beat 2 of a read.
    @(negedge clk); CacheBusRW = 2'b10; BusRData = 32'h77;
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk); #1;
      if (BusValid && BeatCount == 2'd2) begin
        seen = 1'b1;
        break;
      end
    end
    chk("rst_reach_beat2", seen, 1'b1);
    reset = 1'b1;
    @(negedge clk); #1;
    chk("rst_valid", BusValid, 1'b0);
    chk("rst_busy",  BusBusy, 1'b0);
    chk("rst_bc",    BeatCount, 2'd0);
    chk("rst_fb",    FetchBuffer, 128'h0);
    reset = 1'b0; CacheBusRW = 2'b00;

    // Bus never ready.
    @(negedge clk); CacheBusRW = 2'b10; BusReady = 1'b0;
    @(negedge clk); #1;
    chk("to_valid_rise", BusValid, 1'b1);
    ack_at = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk); #1;
      if (CacheBusAck) begin
        ack_at = k;
        break;
      end
    end
`ifdef CACHEBUS_TIMEOUT_EN
    chk("to_ack_cycle", ack_at, 9);
    chk("to_err", BusError, 1'b1);
    CacheBusRW = 2'b00;
`else
    chk("to_no_ack", ack_at, 0);
    chk("to_still_valid", BusValid, 1'b1);
    chk("to_no_err", BusError, 1'b0);
    reset = 1'b1; CacheBusRW = 2'b00;
    @(negedge clk); reset = 1'b0;
`endif
    @(negedge clk); #1;
    chk("end_idle", BusBusy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
